// File: rtl/dmem_bank.sv
// Banked data memory behind the data memory controller: per-channel request FSMs,
// round-robin arbitration onto one storage array, fixed-latency ready pulses, host preload.
module dmem_bank #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
   input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]           mem_read_ready,
   output logic [DATA_BITS*NUM_CHANNELS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
   input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_write_address,
   input  logic [DATA_BITS*NUM_CHANNELS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]           mem_write_ready,
   input  logic                              host_write_en,
   input  logic [ADDR_BITS-1:0]              host_write_address,
   input  logic [DATA_BITS-1:0]              host_write_data
);

   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int PW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP,
      ST_DRAIN
   } ch_state_t;

   ch_state_t              state_q [NUM_CHANNELS];
   ch_state_t              state_d [NUM_CHANNELS];
   logic [CW-1:0]          cnt_q   [NUM_CHANNELS];
   logic [CW-1:0]          cnt_d   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] is_rd_q;
   logic [PW-1:0]          rr_ptr;

   logic [ADDR_BITS-1:0]   rd_addr   [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]   wr_addr   [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   wr_data   [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   rd_data_q [NUM_CHANNELS];

   logic [DATA_BITS-1:0]   mem [DEPTH];

   logic                   grant_vld;
   logic [PW-1:0]          grant_idx;
   logic [PW-1:0]          arb_idx;
   logic                   grant_rd;
   logic                   grant_wr;
   logic [ADDR_BITS-1:0]   grant_addr;
   logic [PW-1:0]          rr_next;

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      assign rd_addr[g] = mem_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_addr[g] = mem_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_data[g] = mem_write_data[g*DATA_BITS +: DATA_BITS];
      assign mem_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
      assign mem_read_ready[g]  = (state_q[g] == ST_RESP) &&  is_rd_q[g];
      assign mem_write_ready[g] = (state_q[g] == ST_RESP) && !is_rd_q[g];
   end

   // Round-robin search from rr_ptr; a host preload blocks every grant that cycle.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      arb_idx   = '0;
      if (!host_write_en) begin
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            arb_idx = PW'((32'(rr_ptr) + i) % NUM_CHANNELS);
            if (!grant_vld && state_q[arb_idx] == ST_IDLE &&
                (mem_read_valid[arb_idx] || mem_write_valid[arb_idx])) begin
               grant_vld = 1'b1;
               grant_idx = arb_idx;
            end
         end
      end
   end

   // Read wins when both valids are high; the write is dropped without a pulse.
   assign grant_rd   = mem_read_valid[grant_idx];
   assign grant_wr   = mem_write_valid[grant_idx] && !mem_read_valid[grant_idx];
   assign grant_addr = grant_rd ? rd_addr[grant_idx] : wr_addr[grant_idx];
   assign rr_next    = (32'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + 1'b1;

   always_comb begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            ST_IDLE: begin
               if (grant_vld && grant_idx == PW'(k)) begin
                  state_d[k] = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                  cnt_d[k]   = CW'(LATENCY - 1);
               end
            end
            ST_BUSY: begin
               cnt_d[k] = cnt_q[k] - 1'b1;
               if (cnt_q[k] == CW'(1)) state_d[k] = ST_RESP;
            end
            ST_RESP:  state_d[k] = ST_DRAIN;
            ST_DRAIN: begin
               if (!mem_read_valid[k] && !mem_write_valid[k]) state_d[k] = ST_IDLE;
            end
            default:  state_d[k] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            state_q[k]   <= ST_IDLE;
            cnt_q[k]     <= '0;
            rd_data_q[k] <= '0;
         end
         is_rd_q <= '0;
         rr_ptr  <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         if (grant_vld) begin
            rr_ptr             <= rr_next;
            is_rd_q[grant_idx] <= grant_rd;
            if (grant_rd) rd_data_q[grant_idx] <= mem[grant_addr];
         end
      end
   end

   // Storage is deliberately outside the reset domain so preloaded data survives reset.
   always_ff @(posedge clk) begin
      if (host_write_en) begin
         mem[host_write_address] <= host_write_data;
      end else if (grant_vld && grant_wr) begin
         mem[grant_addr] <= wr_data[grant_idx];
      end
   end

endmodule

// File: tb/tb_dmem_bank.sv
// Directed self-checking bench for dmem_bank: latency, round-robin order, host
// preload blocking, reset mid-access, read-over-write priority and single-pulse drain.
module tb_dmem_bank;

   localparam int AB  = 8;
   localparam int DB  = 8;
   localparam int NCH = 4;
   localparam int LAT = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NCH-1:0]     rv;
   logic [AB*NCH-1:0]  ra;
   logic [NCH-1:0]     rrdy;
   logic [DB*NCH-1:0]  rdata;
   logic [NCH-1:0]     wv;
   logic [AB*NCH-1:0]  wa;
   logic [DB*NCH-1:0]  wd;
   logic [NCH-1:0]     wrdy;
   logic               host_en;
   logic [AB-1:0]      host_addr;
   logic [DB-1:0]      host_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_bank #(
      .ADDR_BITS(AB),
      .DATA_BITS(DB),
      .NUM_CHANNELS(NCH),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_read_valid(rv),
      .mem_read_address(ra),
      .mem_read_ready(rrdy),
      .mem_read_data(rdata),
      .mem_write_valid(wv),
      .mem_write_address(wa),
      .mem_write_data(wd),
      .mem_write_ready(wrdy),
      .host_write_en(host_en),
      .host_write_address(host_addr),
      .host_write_data(host_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic host_wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
      host_en   = 1'b1;
      host_addr = a;
      host_data = d;
      cyc(1);
      host_en   = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
      host_en = 1'b0; host_addr = '0; host_data = '0;
      cyc(2);
      check("rst_rd_ready", 32'(rrdy), 32'h0);
      check("rst_wr_ready", 32'(wrdy), 32'h0);
      check("rst_rd_data",  rdata,     32'h0);
      reset = 1'b1;
      cyc(1);

      host_wr(8'h10, 8'hAB);
      host_wr(8'h00, 8'hA0);
      host_wr(8'h01, 8'hA1);
      host_wr(8'h02, 8'hA2);
      host_wr(8'h03, 8'hA3);

      // all four channels request together, rr_ptr = 0
      ra = {8'h03, 8'h02, 8'h01, 8'h00};
      rv = 4'b1111;
      check("rr_T0", 32'(rrdy), 32'h0);
      cyc(1); check("rr_T1", 32'(rrdy), 32'h0);
      cyc(1); check("rr_T2", 32'(rrdy), 32'h1); check("rr_d0", 32'(rdata[7:0]),   32'hA0);
      cyc(1); check("rr_T3", 32'(rrdy), 32'h2); check("rr_d1", 32'(rdata[15:8]),  32'hA1);
      cyc(1); check("rr_T4", 32'(rrdy), 32'h4); check("rr_d2", 32'(rdata[23:16]), 32'hA2);
      cyc(1); check("rr_T5", 32'(rrdy), 32'h8); check("rr_d3", 32'(rdata[31:24]), 32'hA3);
      cyc(1); check("rr_T6", 32'(rrdy), 32'h0);
      rv = '0;
      cyc(2);

      // ch0 reads host-preloaded 0x10; exact latency and no repeat pulse
      ra[7:0] = 8'h10;
      rv = 4'b0001;
      check("lat_T0", 32'(rrdy), 32'h0);
      cyc(1); check("lat_T1", 32'(rrdy), 32'h0);
      cyc(1); check("lat_T2", 32'(rrdy), 32'h1); check("lat_data", 32'(rdata[7:0]), 32'hAB);
      cyc(1); check("lat_T3", 32'(rrdy), 32'h0);
      cyc(1); check("lat_T4", 32'(rrdy), 32'h0);
      rv = '0;
      cyc(2);

      // ch2 writes 0x05=0x3C, ch1 reads it back
      wa[23:16] = 8'h05;
      wd[23:16] = 8'h3C;
      wv = 4'b0100;
      cyc(1); check("wr_T1", 32'(wrdy), 32'h0);
      cyc(1); check("wr_T2", 32'(wrdy), 32'h4);
      check("wr_T2_rd", 32'(rrdy), 32'h0);
      check("wr_keep_data", 32'(rdata[23:16]), 32'hA2);
      cyc(1); check("wr_T3", 32'(wrdy), 32'h0);
      wv = '0;
      cyc(2);
      ra[15:8] = 8'h05;
      rv = 4'b0010;
      cyc(2); check("wr_rb_rdy", 32'(rrdy), 32'h2); check("wr_rb_data", 32'(rdata[15:8]), 32'h3C);
      rv = '0;
      cyc(2);

      // host preload for 3 cycles holds off a pending ch0 read
      ra[7:0] = 8'h01;
      rv = 4'b0001;
      host_en = 1'b1; host_addr = 8'h80; host_data = 8'h11;
      cyc(1); host_addr = 8'h81; host_data = 8'h12;
      cyc(1); host_addr = 8'h82; host_data = 8'h13;
      check("host_T2", 32'(rrdy), 32'h0);
      cyc(1); host_en = 1'b0;
      check("host_T3", 32'(rrdy), 32'h0);
      cyc(1); check("host_T4", 32'(rrdy), 32'h0);
      cyc(1); check("host_T5", 32'(rrdy), 32'h1); check("host_data", 32'(rdata[7:0]), 32'hA1);
      cyc(1); check("host_T6", 32'(rrdy), 32'h0);
      rv = '0;
      cyc(2);
      ra[23:16] = 8'h81;
      rv = 4'b0100;
      cyc(2); check("host_rb_rdy", 32'(rrdy), 32'h4); check("host_rb_data", 32'(rdata[23:16]), 32'h12);
      rv = '0;
      cyc(2);

      // reset while ch1 is BUSY
      ra[15:8] = 8'h02;
      rv = 4'b0010;
      cyc(1);
      reset = 1'b0;
      #1;
      check("rstb_rdy",  32'(rrdy), 32'h0);
      check("rstb_data", rdata,     32'h0);
      cyc(1); check("rstb_nopulse", 32'(rrdy), 32'h0);
      reset = 1'b1;
      cyc(1); check("rstb_R1", 32'(rrdy), 32'h0);
      cyc(1); check("rstb_R2", 32'(rrdy), 32'h2); check("rstb_R2_data", 32'(rdata[15:8]), 32'hA2);
      rv = '0;
      cyc(2);

      // move rr_ptr to 3, then ch0 and ch3 contend
      ra[23:16] = 8'h00;
      rv = 4'b0100;
      cyc(2); check("ptr_setup", 32'(rrdy), 32'h4);
      rv = '0;
      cyc(2);
      ra[7:0]   = 8'h00;
      ra[31:24] = 8'h03;
      rv = 4'b1001;
      cyc(2); check("cont_T2", 32'(rrdy), 32'h8); check("cont_d3", 32'(rdata[31:24]), 32'hA3);
      cyc(1); check("cont_T3", 32'(rrdy), 32'h1); check("cont_d0", 32'(rdata[7:0]),   32'hA0);
      rv[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("hold_nopulse", 32'(rrdy), 32'h0);
      end
      rv = '0;
      cyc(2);

      // read and write on one channel: read served, write dropped
      ra[15:8] = 8'h01;
      wa[15:8] = 8'h00;
      wd[15:8] = 8'hFF;
      rv = 4'b0010;
      wv = 4'b0010;
      cyc(2);
      check("rw_rd_rdy", 32'(rrdy), 32'h2);
      check("rw_wr_rdy", 32'(wrdy), 32'h0);
      check("rw_data",   32'(rdata[15:8]), 32'hA1);
      cyc(1); check("rw_wr_rdy_T3", 32'(wrdy), 32'h0);
      rv = '0;
      wv = '0;
      cyc(2);
      ra[7:0] = 8'h00;
      rv = 4'b0001;
      cyc(2); check("rw_mem_kept", 32'(rdata[7:0]), 32'hA0);
      rv = '0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
